mac_pipe_sched: RTL

MAC_PIPE_SCHED -- requirements
Module: mac_pipe_sched

---
 rtl/mac_pipe_sched.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mac_pipe_sched.sv
// mac_pipe_sched: two requesters share one 3-stage MAC pipeline, (a+b)*c+c.
// Optional MAC_PIPE_SCHED_STATS_EN adds per-requester grant counters.
//
// Ports:
//   clk, rst (sync, active-high)  - clock and reset
//   hold                          - freezes pipeline, blocks grants
//   reqN_valid/ready, reqN_a/b/c  - requester handshake and operands (N=0,1)
//   res_valid, res_id, res_data   - result, one cycle per op, no backpressure
//   gnt0_cnt, gnt1_cnt            - saturating grant counts (stats build only)
module mac_pipe_sched #(
    parameter int DW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            req0_valid,
    input  logic [DW-1:0]   req0_a,
    input  logic [DW-1:0]   req0_b,
    input  logic [DW-1:0]   req0_c,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [DW-1:0]   req1_a,
    input  logic [DW-1:0]   req1_b,
    input  logic [DW-1:0]   req1_c,
    output logic            req1_ready,
    output logic            res_valid,
    output logic            res_id,
    output logic [2*DW-1:0] res_data
`ifdef MAC_PIPE_SCHED_STATS_EN
    ,
    output logic [7:0]      gnt0_cnt,
    output logic [7:0]      gnt1_cnt
`endif
);

    localparam int RW = 2 * DW;

    typedef struct packed {
        logic          v;
        logic          id;
        logic [RW-1:0] d;
        logic [DW-1:0] c;
    } stage_t;

    stage_t        s1;
    stage_t        s2;
    logic          s3_v;
    logic          s3_id;
    logic [RW-1:0] s3_d;
    logic          rr;

    logic          gnt0;
    logic          gnt1;
    logic          xfer;
    logic [DW-1:0] sel_a;
    logic [DW-1:0] sel_b;
    logic [DW-1:0] sel_c;
    logic [RW-1:0] sum_n;
    logic [RW-1:0] prod_n;
    logic [RW-1:0] acc_n;

    // rr names the requester that wins when both are valid.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && !hold) begin
            if (req0_valid && (!req1_valid || !rr)) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign xfer       = gnt0 | gnt1;

    assign sel_a = gnt1 ? req1_a : req0_a;
    assign sel_b = gnt1 ? req1_b : req0_b;
    assign sel_c = gnt1 ? req1_c : req0_c;

    assign sum_n  = RW'(sel_a) + RW'(sel_b);
    assign prod_n = s1.d * RW'(s1.c);
    assign acc_n  = s2.d + RW'(s2.c);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1.v      <= 1'b0;
            s2.v      <= 1'b0;
            s3_v      <= 1'b0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            res_data  <= '0;
            rr        <= 1'b0;
        end else if (!hold) begin
            // A non-transfer cycle shifts a bubble into S1.
            s1 <= '{v: xfer, id: gnt1, d: sum_n, c: sel_c};
            s2 <= '{v: s1.v, id: s1.id, d: prod_n, c: s1.c};
            s3_v  <= s2.v;
            s3_id <= s2.id;
            s3_d  <= acc_n;
            res_valid <= s3_v;
            // Last result stays visible between valid pulses.
            if (s3_v) begin
                res_id   <= s3_id;
                res_data <= s3_d;
            end
            if (xfer) begin
                rr <= gnt0;
            end
        end
    end

`ifdef MAC_PIPE_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0_cnt <= '0;
            gnt1_cnt <= '0;
        end else begin
            if (gnt0 && gnt0_cnt != 8'hff) begin
                gnt0_cnt <= gnt0_cnt + 8'd1;
            end
            if (gnt1 && gnt1_cnt != 8'hff) begin
                gnt1_cnt <= gnt1_cnt + 8'd1;
            end
        end
    end
`endif

endmodule
